// File: rtl/rx_app_ptr_consumer.sv
// rx_app_ptr_consumer: app-side consumer of the per-flow RX payload pointer store.
// Takes "consume up to N bytes of flow F", reads head/commit, grants min(N, committed)
// and writes back the advanced head pointer.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   app_req_*   (val/rdy)         consume request: flowid, len
//   app_resp_*  (val/rdy)         grant: flowid, addr (old head offset), len
//   head_rd_req_* / head_rd_resp_*  head pointer read port
//   cmt_rd_req_*  / cmt_rd_resp_*   commit pointer read port
//   head_wr_req_*                 head pointer write port
//
// Optional feature: RX_APP_PTR_BYPASS_EN
//   undefined: a SETTLE cycle follows every grant so the store can absorb the head write.
//   defined:   SETTLE is dropped; the last written head is forwarded to a same-flow
//              request, skipping its head read.
module rx_app_ptr_consumer #(
  parameter int FLOWID_W = 3,
  parameter int PTR_W    = 16,
  parameter int LEN_W    = 17
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                app_req_val_i,
  output logic                app_req_rdy_o,
  input  logic [FLOWID_W-1:0] app_req_flowid_i,
  input  logic [LEN_W-1:0]    app_req_len_i,

  output logic                app_resp_val_o,
  input  logic                app_resp_rdy_i,
  output logic [FLOWID_W-1:0] app_resp_flowid_o,
  output logic [PTR_W-1:0]    app_resp_addr_o,
  output logic [LEN_W-1:0]    app_resp_len_o,

  output logic                head_rd_req_val_o,
  input  logic                head_rd_req_rdy_i,
  output logic [FLOWID_W-1:0] head_rd_req_addr_o,
  input  logic                head_rd_resp_val_i,
  output logic                head_rd_resp_rdy_o,
  input  logic [PTR_W:0]      head_rd_resp_data_i,

  output logic                cmt_rd_req_val_o,
  input  logic                cmt_rd_req_rdy_i,
  output logic [FLOWID_W-1:0] cmt_rd_req_addr_o,
  input  logic                cmt_rd_resp_val_i,
  output logic                cmt_rd_resp_rdy_o,
  input  logic [PTR_W:0]      cmt_rd_resp_data_i,

  output logic                head_wr_req_val_o,
  input  logic                head_wr_req_rdy_i,
  output logic [FLOWID_W-1:0] head_wr_req_addr_o,
  output logic [PTR_W:0]      head_wr_req_data_o
);

  localparam int PW = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_RESP, CALC, WR_RESP, SETTLE
  } state_e;

  state_e state_q, state_d;

  logic                rdy_q, rdy_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       cmt_q, cmt_d;
  logic                hq_done_q, hq_done_d;
  logic                cq_done_q, cq_done_d;
  logic                h_have_q, h_have_d;
  logic                c_have_q, c_have_d;
  logic [LEN_W-1:0]    grant_q, grant_d;
  logic [PW-1:0]       nhead_q, nhead_d;
  logic                resp_done_q, resp_done_d;
  logic                wr_done_q, wr_done_d;

  logic [PW-1:0] avail, len_x, grant_x;
  logic          h_ok, c_ok, r_ok, w_ok;

`ifdef RX_APP_PTR_BYPASS_EN
  logic                last_vld_q, last_vld_d;
  logic [FLOWID_W-1:0] last_flowid_q, last_flowid_d;
  logic [PW-1:0]       last_head_q, last_head_d;
`endif

  // Ready is registered so it stays low for the first cycle after reset.
  assign app_req_rdy_o = rdy_q;

  assign app_resp_flowid_o  = flowid_q;
  assign app_resp_addr_o    = head_q[PTR_W-1:0];
  assign app_resp_len_o     = grant_q;
  assign head_rd_req_addr_o = flowid_q;
  assign cmt_rd_req_addr_o  = flowid_q;
  assign head_wr_req_addr_o = flowid_q;
  assign head_wr_req_data_o = nhead_q;

  // Pointers are compared with the wrap bit, so the difference is the fill level.
  assign avail   = cmt_q - head_q;
  assign len_x   = PW'(len_q);
  assign grant_x = (len_x < avail) ? len_x : avail;

  always_comb begin
    state_d     = state_q;
    flowid_d    = flowid_q;
    len_d       = len_q;
    head_d      = head_q;
    cmt_d       = cmt_q;
    hq_done_d   = hq_done_q;
    cq_done_d   = cq_done_q;
    h_have_d    = h_have_q;
    c_have_d    = c_have_q;
    grant_d     = grant_q;
    nhead_d     = nhead_q;
    resp_done_d = resp_done_q;
    wr_done_d   = wr_done_q;
`ifdef RX_APP_PTR_BYPASS_EN
    last_vld_d    = last_vld_q;
    last_flowid_d = last_flowid_q;
    last_head_d   = last_head_q;
`endif
    app_resp_val_o     = 1'b0;
    head_rd_req_val_o  = 1'b0;
    cmt_rd_req_val_o   = 1'b0;
    head_rd_resp_rdy_o = 1'b0;
    cmt_rd_resp_rdy_o  = 1'b0;
    head_wr_req_val_o  = 1'b0;
    h_ok = 1'b0;
    c_ok = 1'b0;
    r_ok = 1'b0;
    w_ok = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (app_req_val_i && app_req_rdy_o) begin
          flowid_d  = app_req_flowid_i;
          len_d     = app_req_len_i;
          hq_done_d = 1'b0;
          cq_done_d = 1'b0;
          h_have_d  = 1'b0;
          c_have_d  = 1'b0;
          state_d   = RD_REQ;
`ifdef RX_APP_PTR_BYPASS_EN
          if (last_vld_q && last_flowid_q == app_req_flowid_i) begin
            hq_done_d = 1'b1;
            h_have_d  = 1'b1;
            head_d    = last_head_q;
          end
`endif
        end
      end
      RD_REQ: begin
        head_rd_req_val_o = !hq_done_q;
        cmt_rd_req_val_o  = !cq_done_q;
        h_ok = hq_done_q | head_rd_req_rdy_i;
        c_ok = cq_done_q | cmt_rd_req_rdy_i;
        hq_done_d = h_ok;
        cq_done_d = c_ok;
        if (h_ok && c_ok) state_d = RD_RESP;
      end
      RD_RESP: begin
        head_rd_resp_rdy_o = !h_have_q;
        cmt_rd_resp_rdy_o  = !c_have_q;
        if (!h_have_q && head_rd_resp_val_i) begin
          head_d   = head_rd_resp_data_i;
          h_have_d = 1'b1;
        end
        if (!c_have_q && cmt_rd_resp_val_i) begin
          cmt_d    = cmt_rd_resp_data_i;
          c_have_d = 1'b1;
        end
        h_ok = h_have_q | head_rd_resp_val_i;
        c_ok = c_have_q | cmt_rd_resp_val_i;
        if (h_ok && c_ok) state_d = CALC;
      end
      CALC: begin
        grant_d     = grant_x[LEN_W-1:0];
        nhead_d     = head_q + grant_x;
        resp_done_d = 1'b0;
        // A zero grant leaves the head untouched, so no write is issued.
        wr_done_d   = (grant_x == '0);
        state_d     = WR_RESP;
      end
      WR_RESP: begin
        app_resp_val_o    = !resp_done_q;
        head_wr_req_val_o = !wr_done_q;
        r_ok = resp_done_q | app_resp_rdy_i;
        w_ok = wr_done_q | head_wr_req_rdy_i;
        resp_done_d = r_ok;
        wr_done_d   = w_ok;
`ifdef RX_APP_PTR_BYPASS_EN
        if (!wr_done_q && head_wr_req_rdy_i) begin
          last_vld_d    = 1'b1;
          last_flowid_d = flowid_q;
          last_head_d   = nhead_q;
        end
        if (r_ok && w_ok) state_d = IDLE;
`else
        if (r_ok && w_ok) state_d = SETTLE;
`endif
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      flowid_q    <= '0;
      len_q       <= '0;
      head_q      <= '0;
      cmt_q       <= '0;
      hq_done_q   <= 1'b0;
      cq_done_q   <= 1'b0;
      h_have_q    <= 1'b0;
      c_have_q    <= 1'b0;
      grant_q     <= '0;
      nhead_q     <= '0;
      resp_done_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      flowid_q    <= flowid_d;
      len_q       <= len_d;
      head_q      <= head_d;
      cmt_q       <= cmt_d;
      hq_done_q   <= hq_done_d;
      cq_done_q   <= cq_done_d;
      h_have_q    <= h_have_d;
      c_have_q    <= c_have_d;
      grant_q     <= grant_d;
      nhead_q     <= nhead_d;
      resp_done_q <= resp_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

`ifdef RX_APP_PTR_BYPASS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_vld_q    <= 1'b0;
      last_flowid_q <= '0;
      last_head_q   <= '0;
    end else begin
      last_vld_q    <= last_vld_d;
      last_flowid_q <= last_flowid_d;
      last_head_q   <= last_head_d;
    end
  end
`endif

endmodule

// File: tb/tb_rx_app_ptr_consumer.sv
// tb_rx_app_ptr_consumer: directed bench for rx_app_ptr_consumer.
// A small pointer-store model answers reads/writes; each task checks one scenario.
module tb_rx_app_ptr_consumer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        app_req_val_i = 1'b0;
  logic        app_req_rdy_o;
  logic [2:0]  app_req_flowid_i = '0;
  logic [16:0] app_req_len_i = '0;
  logic        app_resp_val_o;
  logic        app_resp_rdy_i = 1'b1;
  logic [2:0]  app_resp_flowid_o;
  logic [15:0] app_resp_addr_o;
  logic [16:0] app_resp_len_o;
  logic        head_rd_req_val_o;
  logic        head_rd_req_rdy_i = 1'b1;
  logic [2:0]  head_rd_req_addr_o;
  logic        head_rd_resp_val_i = 1'b0;
  logic        head_rd_resp_rdy_o;
  logic [16:0] head_rd_resp_data_i = '0;
  logic        cmt_rd_req_val_o;
  logic        cmt_rd_req_rdy_i = 1'b1;
  logic [2:0]  cmt_rd_req_addr_o;
  logic        cmt_rd_resp_val_i = 1'b0;
  logic        cmt_rd_resp_rdy_o;
  logic [16:0] cmt_rd_resp_data_i = '0;
  logic        head_wr_req_val_o;
  logic        head_wr_req_rdy_i = 1'b1;
  logic [2:0]  head_wr_req_addr_o;
  logic [16:0] head_wr_req_data_o;

  rx_app_ptr_consumer dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .app_req_val_i       (app_req_val_i),
    .app_req_rdy_o       (app_req_rdy_o),
    .app_req_flowid_i    (app_req_flowid_i),
    .app_req_len_i       (app_req_len_i),
    .app_resp_val_o      (app_resp_val_o),
    .app_resp_rdy_i      (app_resp_rdy_i),
    .app_resp_flowid_o   (app_resp_flowid_o),
    .app_resp_addr_o     (app_resp_addr_o),
    .app_resp_len_o      (app_resp_len_o),
    .head_rd_req_val_o   (head_rd_req_val_o),
    .head_rd_req_rdy_i   (head_rd_req_rdy_i),
    .head_rd_req_addr_o  (head_rd_req_addr_o),
    .head_rd_resp_val_i  (head_rd_resp_val_i),
    .head_rd_resp_rdy_o  (head_rd_resp_rdy_o),
    .head_rd_resp_data_i (head_rd_resp_data_i),
    .cmt_rd_req_val_o    (cmt_rd_req_val_o),
    .cmt_rd_req_rdy_i    (cmt_rd_req_rdy_i),
    .cmt_rd_req_addr_o   (cmt_rd_req_addr_o),
    .cmt_rd_resp_val_i   (cmt_rd_resp_val_i),
    .cmt_rd_resp_rdy_o   (cmt_rd_resp_rdy_o),
    .cmt_rd_resp_data_i  (cmt_rd_resp_data_i),
    .head_wr_req_val_o   (head_wr_req_val_o),
    .head_wr_req_rdy_i   (head_wr_req_rdy_i),
    .head_wr_req_addr_o  (head_wr_req_addr_o),
    .head_wr_req_data_o  (head_wr_req_data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ecnt = 0;
  bit rst_s = 1'b0;
  always @(posedge clk) ecnt <= ecnt + 1;
  always @(posedge clk) rst_s <= rst_n;

  // pointer store model
  logic [16:0] head_mem [8];
  logic [16:0] cmt_mem [8];
  int hdly = 0, cdly = 0, wstall = 0, astall = 0;
  int hcnt = -1, ccnt = -1;
  logic [16:0] hdat, cdat;
  int hrd_cnt = 0, crd_cnt = 0, w_cnt = 0, r_cnt = 0, wvc = 0;
  logic [2:0]  w_addr, r_flow;
  logic [16:0] w_data, r_len;
  logic [15:0] r_addr;
  bit rv_seen = 0;
  int rv_edge = 0;
  int acc_edge = 0;

  bit hq_p = 0, cq_p = 0, hr_p = 0, cr_p = 0, w_p = 0, a_p = 0;
  logic [2:0]  hq_a, cq_a, w_pa, a_f;
  logic [16:0] w_pd, a_l;
  logic [15:0] a_ad;

  // Runs at negedge+1: retire handshakes of the previous posedge, then
  // update the model's outputs and predict the next edge's handshakes.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst_s) begin
        hcnt = -1; ccnt = -1; rv_seen = 0;
        head_rd_resp_val_i = 1'b0;
        cmt_rd_resp_val_i  = 1'b0;
      end else begin
        if (hq_p) begin hcnt = hdly; hdat = head_mem[hq_a]; hrd_cnt++; end
        if (cq_p) begin ccnt = cdly; cdat = cmt_mem[cq_a]; crd_cnt++; end
        if (hr_p) head_rd_resp_val_i = 1'b0;
        if (cr_p) cmt_rd_resp_val_i = 1'b0;
        if (w_p) begin
          head_mem[w_pa] = w_pd; w_cnt++; w_addr = w_pa; w_data = w_pd;
        end
        if (a_p) begin
          r_cnt++; r_flow = a_f; r_addr = a_ad; r_len = a_l; rv_seen = 0;
        end
      end
      if (hcnt >= 0) begin
        if (hcnt == 0) begin head_rd_resp_val_i = 1'b1; head_rd_resp_data_i = hdat; end
        hcnt--;
      end
      if (ccnt >= 0) begin
        if (ccnt == 0) begin cmt_rd_resp_val_i = 1'b1; cmt_rd_resp_data_i = cdat; end
        ccnt--;
      end
      if (head_wr_req_val_o === 1'b1 && wstall > 0) begin
        head_wr_req_rdy_i = 1'b0; wstall--;
      end else head_wr_req_rdy_i = 1'b1;
      if (app_resp_val_o === 1'b1 && astall > 0) begin
        app_resp_rdy_i = 1'b0; astall--;
      end else app_resp_rdy_i = 1'b1;
      if (head_wr_req_val_o === 1'b1) wvc++;
      if (app_resp_val_o === 1'b1 && !rv_seen) begin rv_seen = 1; rv_edge = ecnt; end
      hq_p = (head_rd_req_val_o && head_rd_req_rdy_i);
      hq_a = head_rd_req_addr_o;
      cq_p = (cmt_rd_req_val_o && cmt_rd_req_rdy_i);
      cq_a = cmt_rd_req_addr_o;
      hr_p = (head_rd_resp_val_i && head_rd_resp_rdy_o);
      cr_p = (cmt_rd_resp_val_i && cmt_rd_resp_rdy_o);
      w_p  = (head_wr_req_val_o && head_wr_req_rdy_i);
      w_pa = head_wr_req_addr_o;
      w_pd = head_wr_req_data_o;
      a_p  = (app_resp_val_o && app_resp_rdy_i);
      a_f  = app_resp_flowid_o;
      a_ad = app_resp_addr_o;
      a_l  = app_resp_len_o;
    end
  end

  // Tasks run at negedge+3.
  task automatic step();
    @(negedge clk); #3;
  endtask

  task automatic do_req(input logic [2:0] f, input logic [16:0] l);
    int n = 0;
    app_req_val_i = 1'b1; app_req_flowid_i = f; app_req_len_i = l;
    while (app_req_rdy_o !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (app_req_rdy_o !== 1'b1) begin
      errors++; $display("FAIL req_accept: rdy %b after %0d cycles, want 1", app_req_rdy_o, n);
    end
    acc_edge = ecnt + 1;
    step();
    app_req_val_i = 1'b0;
  endtask

  task automatic wait_resp(input int start);
    int n = 0;
    while (r_cnt == start && n < 100) begin step(); n++; end
    checks++;
    if (r_cnt == start) begin
      errors++; $display("FAIL resp_timeout: no app response in %0d cycles, want one", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (app_req_rdy_o !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (app_req_rdy_o !== 1'b1) begin
      errors++; $display("FAIL idle_timeout: rdy %b after %0d cycles, want 1", app_req_rdy_o, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (app_req_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_req_rdy: got %b want 0", app_req_rdy_o); end
    checks++;
    if ({app_resp_val_o, head_rd_req_val_o, cmt_rd_req_val_o, head_wr_req_val_o} !== 4'b0) begin
      errors++;
      $display("FAIL rst_vals: got %b%b%b%b want 0000", app_resp_val_o, head_rd_req_val_o,
               cmt_rd_req_val_o, head_wr_req_val_o);
    end
    checks++;
    if (app_resp_len_o !== 17'h0 || head_wr_req_data_o !== 17'h0) begin
      errors++; $display("FAIL rst_regs: len %h data %h want 0 0", app_resp_len_o, head_wr_req_data_o);
    end
    rst_n = 1'b1;
    checks++;
    if (app_req_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_rel_rdy0: got %b want 0", app_req_rdy_o); end
    step();
    checks++;
    if (app_req_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_rel_rdy1: got %b want 1", app_req_rdy_o); end
  endtask

  task automatic test_basic();
    int r0 = r_cnt, w0 = w_cnt, h0 = hrd_cnt, c0 = crd_cnt, lat;
    head_mem[2] = 17'h00100; cmt_mem[2] = 17'h00180;
    do_req(3'd2, 17'h40);
    wait_resp(r0);
    lat = rv_edge - acc_edge + 1;
    checks++;
    if (r_flow !== 3'd2 || r_addr !== 16'h0100 || r_len !== 17'h40) begin
      errors++; $display("FAIL basic_resp: flow %0d addr %h len %h want 2 0100 00040", r_flow, r_addr, r_len);
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    wait_idle();
    checks++;
    if (w_cnt != w0 + 1 || w_addr !== 3'd2 || w_data !== 17'h00140) begin
      errors++; $display("FAIL basic_write: n %0d addr %0d data %h want 1 2 00140", w_cnt - w0, w_addr, w_data);
    end
    checks++;
    if (hrd_cnt != h0 + 1 || crd_cnt != c0 + 1) begin
      errors++; $display("FAIL basic_reads: head %0d cmt %0d want 1 1", hrd_cnt - h0, crd_cnt - c0);
    end
  endtask

  task automatic test_empty();
    int r0 = r_cnt, w0 = w_cnt, v0 = wvc;
    head_mem[3] = 17'h00200; cmt_mem[3] = 17'h00200;
    do_req(3'd3, 17'h10);
    wait_resp(r0);
    wait_idle();
    checks++;
    if (r_addr !== 16'h0200 || r_len !== 17'h0) begin
      errors++; $display("FAIL empty_resp: addr %h len %h want 0200 00000", r_addr, r_len);
    end
    checks++;
    if (w_cnt != w0 || wvc != v0) begin
      errors++; $display("FAIL empty_nowrite: writes %0d val_cycles %0d want 0 0", w_cnt - w0, wvc - v0);
    end
  endtask

  task automatic test_wrap();
    int r0 = r_cnt;
    head_mem[4] = 17'h1FFF0; cmt_mem[4] = 17'h00010;
    do_req(3'd4, 17'h100);
    wait_resp(r0);
    wait_idle();
    checks++;
    if (r_addr !== 16'hFFF0 || r_len !== 17'h20) begin
      errors++; $display("FAIL wrap_resp: addr %h len %h want fff0 00020", r_addr, r_len);
    end
    checks++;
    if (w_addr !== 3'd4 || w_data !== 17'h00010) begin
      errors++; $display("FAIL wrap_write: addr %0d data %h want 4 00010", w_addr, w_data);
    end
  endtask

  task automatic test_len0();
    int r0 = r_cnt, w0 = w_cnt, v0 = wvc;
    head_mem[5] = 17'h00010; cmt_mem[5] = 17'h00050;
    do_req(3'd5, 17'h0);
    wait_resp(r0);
    wait_idle();
    checks++;
    if (r_addr !== 16'h0010 || r_len !== 17'h0 || w_cnt != w0 || wvc != v0) begin
      errors++;
      $display("FAIL len0: addr %h len %h writes %0d want 0010 00000 0", r_addr, r_len, w_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    int r0 = r_cnt, w0 = w_cnt;
    head_mem[6] = 17'h00300; cmt_mem[6] = 17'h003A0;
    hdly = 3; cdly = 0; wstall = 5;
    do_req(3'd6, 17'h200);
    wait_resp(r0);
    checks++;
    if (head_wr_req_val_o !== 1'b1 || app_req_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: wr_val %b req_rdy %b want 1 0", head_wr_req_val_o, app_req_rdy_o);
    end
    wait_idle();
    checks++;
    if (w_cnt != w0 + 1) begin errors++; $display("FAIL bp_retire: writes %0d at ready, want 1", w_cnt - w0); end
    checks++;
    if (r_addr !== 16'h0300 || r_len !== 17'hA0 || w_data !== 17'h003A0) begin
      errors++; $display("FAIL bp_values: addr %h len %h data %h want 0300 000a0 003a0", r_addr, r_len, w_data);
    end
    hdly = 0;
  endtask

  task automatic test_back_to_back();
    int r0, h0 = hrd_cnt, c0 = crd_cnt, hexp;
    head_mem[1] = 17'h0; cmt_mem[1] = 17'h00040;
    r0 = r_cnt;
    do_req(3'd1, 17'h10);
    wait_resp(r0);
    checks++;
    if (r_addr !== 16'h0000 || r_len !== 17'h10) begin
      errors++; $display("FAIL b2b_first: addr %h len %h want 0000 00010", r_addr, r_len);
    end
    r0 = r_cnt;
    do_req(3'd1, 17'h10);
    wait_resp(r0);
    checks++;
    if (r_addr !== 16'h0010 || r_len !== 17'h10) begin
      errors++; $display("FAIL b2b_second: addr %h len %h want 0010 00010", r_addr, r_len);
    end
    wait_idle();
    checks++;
    if (head_mem[1] !== 17'h00020) begin
      errors++; $display("FAIL b2b_head: got %h want 00020", head_mem[1]);
    end
`ifdef RX_APP_PTR_BYPASS_EN
    hexp = 1;
`else
    hexp = 2;
`endif
    checks++;
    if (hrd_cnt - h0 != hexp || crd_cnt - c0 != 2) begin
      errors++; $display("FAIL b2b_reads: head %0d cmt %0d want %0d 2", hrd_cnt - h0, crd_cnt - c0, hexp);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, w0 = w_cnt;
    head_mem[7] = 17'h0; cmt_mem[7] = 17'h00100;
    wstall = 20; astall = 20;
    do_req(3'd7, 17'h20);
    while (head_wr_req_val_o !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (head_wr_req_val_o !== 1'b1) begin
      errors++; $display("FAIL rmid_reach: wr_val %b want 1", head_wr_req_val_o);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({app_resp_val_o, head_rd_req_val_o, cmt_rd_req_val_o, head_wr_req_val_o, app_req_rdy_o} !== 5'b0) begin
      errors++;
      $display("FAIL rmid_vals: got %b%b%b%b rdy %b want 0000 0", app_resp_val_o, head_rd_req_val_o,
               cmt_rd_req_val_o, head_wr_req_val_o, app_req_rdy_o);
    end
    wstall = 0; astall = 0;
    rst_n = 1'b1;
    step();
    checks++;
    if (app_req_rdy_o !== 1'b1) begin errors++; $display("FAIL rmid_rdy: got %b want 1", app_req_rdy_o); end
    checks++;
    if (w_cnt != w0 || head_mem[7] !== 17'h0) begin
      errors++; $display("FAIL rmid_dropped: writes %0d head %h want 0 00000", w_cnt - w0, head_mem[7]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin head_mem[i] = '0; cmt_mem[i] = '0; end
    test_reset();
    test_basic();
    test_empty();
    test_wrap();
    test_len0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
